// File: rtl/sram_pipe.sv
// sram_pipe: parametrised single-port synchronous SRAM with per-byte write
// enables, a ready/valid read return path of RD_LAT cycles, a hardware
// init-clear of every word after reset, and out-of-range address reporting.
// Optional feature macro: SRAM_PARITY_EN adds one even-parity bit per byte,
// a parity-corrupt inject on writes and a parity mismatch flag on reads.
module sram_pipe #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter int                RD_LAT   = 2,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  par_inj,
    output logic                  ready,
    output logic                  rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  err,
    output logic                  par_err
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LAST  = RD_LAT - 1;
    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_IDLE = 1'b1;

    logic [0:0]        state;
    logic [IDX_W-1:0]  init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              acc;
    logic              acc_rd;
    logic              acc_wr;
    logic              wr_oor;
    logic [DATA_W-1:0] rd_word;

    logic              vld_p  [RD_LAT];
    logic              oor_p  [RD_LAT];
    logic [DATA_W-1:0] data_p [RD_LAT];

    assign ready    = (state == ST_IDLE);
    assign idx      = addr[IDX_W-1:0];
    assign in_range = ({1'b0, addr} < DEPTH_C);
    assign acc      = en & ready;
    assign acc_rd   = acc & ~we;
    assign acc_wr   = acc & we;
    assign wr_oor   = acc_wr & ~in_range;
    // Out-of-range reads deliver zero rather than whatever the index aliases to.
    assign rd_word  = in_range ? mem[idx] : '0;

    // Init-clear sequencer: one INIT_VAL word per cycle, then IDLE until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else if (state == ST_INIT) begin
            if (init_cnt == LAST_IDX) begin
                state <= ST_IDLE;
            end else begin
                init_cnt <= init_cnt + IDX_W'(1);
            end
        end
    end

    // Storage array: init-clear writes take priority; accepted writes merge per byte.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (acc_wr && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // ---- stage p0 (accept edge) through p[RD_LAT-1]: read valid shift ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_p[i] <= 1'b0;
            end
        end else begin
            vld_p[0] <= acc_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    // Read data and range flag travel alongside the valid shift, unreset.
    always_ff @(posedge clk) begin
        if (acc_rd) begin
            data_p[0] <= rd_word;
            oor_p[0]  <= ~in_range;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            data_p[i] <= data_p[i-1];
            oor_p[i]  <= oor_p[i-1];
        end
    end

    // ---- output stage: RD_LAT edges after accept; rdata holds between reads ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            err    <= 1'b0;
        end else begin
            rvalid <= vld_p[LAST];
            if (vld_p[LAST]) begin
                rdata <= data_p[LAST];
            end
            err <= wr_oor | (vld_p[LAST] & oor_p[LAST]);
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic          rd_perr;
    logic          perr_p [RD_LAT];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) begin
            p[i] = ^w[8*i +: 8];
        end
        return p;
    endfunction

    assign wr_par  = byte_par(wdata) ^ {NB{par_inj}};
    assign rd_perr = in_range && (par_mem[idx] != byte_par(rd_word));

    // Parity array mirrors the data array's write rules, one bit per byte.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            par_mem[init_cnt] <= byte_par(INIT_VAL);
        end else if (acc_wr && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    par_mem[idx][i] <= wr_par[i];
                end
            end
        end
    end

    // Parity verdict follows its read down the pipeline.
    always_ff @(posedge clk) begin
        if (acc_rd) begin
            perr_p[0] <= rd_perr;
        end
        for (int i = 1; i < RD_LAT; i++) begin
            perr_p[i] <= perr_p[i-1];
        end
    end

    // Parity flag registered coincident with rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= vld_p[LAST] & perr_p[LAST];
        end
    end
`else
    logic unused_par_inj;
    assign unused_par_inj = par_inj;
    assign par_err        = 1'b0;
`endif

endmodule

// File: doc/sram_pipe.md
Name: sram_pipe

Overview:
- Parametrised successor to the single-port synchronous SRAM: configurable data width, depth and read latency.
- Adds per-byte write enables, a ready/valid handshake, a hardware init-clear sequence after reset and out-of-range address detection.
- Sits behind the same en/we/addr/wdata/rdata style interface used by the SRAM environment.
- Drop-in for bench reuse with the extra handshake signals.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width in bits.
- DEPTH, 256, number of words implemented; 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 2, read latency in cycles from acceptance to rvalid; legal range 1..4.
- INIT_VAL, 0, word value written to every location during init-clear.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  access request.
- we  in  1  1 = write, 0 = read; sampled with en.
- be  in  DATA_W/8  byte write enables; be[i] covers wdata[8i+7:8i].
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- par_inj  in  1  parity-corrupt inject on write; see Optional Feature.
- ready  out  1  block accepts requests.
- rvalid  out  1  read data valid, one-cycle pulse per read.
- rdata  out  DATA_W  read data.
- err  out  1  out-of-range address flag, one-cycle pulse.
- par_err  out  1  parity mismatch flag on read.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0), taking effect immediately:
  - ready=0, rvalid=0, rdata=0, err=0, par_err=0.
  - Read pipeline flushed; FSM forced to INIT; init counter=0.
  - Memory array is not reset directly.
- FSM INIT:
  - Entered on reset release.
  - Writes INIT_VAL to address 0,1,...,DEPTH-1, one word per cycle; takes DEPTH cycles.
  - ready=0 throughout; en ignored (no write, no rvalid, no err).
- FSM IDLE:
  - Entered the cycle after the last init write; ready=1 from then on.
  - No transitions out of IDLE except reset.
- Acceptance: en=1 and ready=1 at a rising edge. One request per cycle; full throughput, no stalls in IDLE.
- Write (we=1, addr<DEPTH):
  - Bytes with be[i]=1 updated at the accept edge; other bytes unchanged.
  - be=0 is a legal no-op (no err).
- Read (we=0, addr<DEPTH):
  - rvalid=1 for exactly one cycle, RD_LAT cycles after the accept edge.
  - rdata carries the word at acceptance time.
  - Back-to-back reads return in issue order, one per cycle.
- Read after write to the same address in the next cycle returns the new data. Single-port, so no same-cycle conflict.
- rdata holds its last delivered value while rvalid=0.
- Out-of-range (addr>=DEPTH):
  - Write: memory unchanged; err=1 for the cycle after acceptance.
  - Read: rvalid still pulses at RD_LAT with rdata=0 and err=1 coincident with rvalid.
  - If a write err and a read err fall in the same cycle, err=1 (OR).
- Reset mid-operation: in-flight reads discarded (no rvalid), init-clear reruns in full, all prior data lost.

Optional Feature:
- Macro SRAM_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte, written with its byte.
  - Parity bits are inverted when par_inj=1 on an accepted write.
  - INIT writes correct parity.
  - On each in-range read, recomputed parity is compared with stored parity; par_err=1 coincident with rvalid if any enabled byte mismatches.
  - Out-of-range reads give par_err=0.
- Undefined: no parity storage; par_inj ignored; par_err tied 0.

Test Plan:
1. Reset release with DEPTH=256, RD_LAT=2 -> ready=0 for 256 cycles, then 1; read 0x10 -> rvalid 2 cycles later, rdata=0x00000000.
2. Write 0x10=0xDEADBEEF be=0xF; write 0x10=0x11223344 be=0x5; read 0x10 -> rdata=0xDE22BE44.
3. Write 0x00..0x03 = 0xA0..0xA3; reads of 0x00..0x03 on 4 consecutive cycles -> rvalid high 4 consecutive cycles starting 2 cycles after the first accept, data 0xA0,0xA1,0xA2,0xA3 in order.
4. DEPTH=200: write 0xC8 -> err=1 one cycle later, 0x00 unchanged; read 0xC8 -> rvalid=1, rdata=0, err=1 same cycle.
5. Read accepted, rst=0 the next cycle -> no rvalid; after release ready=0 for DEPTH cycles; read of a previously written address returns INIT_VAL.
6. With SRAM_PARITY_EN: write 0x05=0x12345678 par_inj=1, read 0x05 -> par_err=1 with rvalid. Without the macro -> par_err=0, rdata=0x12345678.
